// File: rtl/spi_link_pkg.sv
// Shared types and helpers for the SPI up-counter link.
// Used by the master source and by the slave-side reassembly.
package spi_link_pkg;

    localparam int COUNT_W = 14;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT0,
        GAP,
        SHIFT1,
        HOLD,
        SPACE
    } link_state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } frame_bytes_t;

    function automatic frame_bytes_t split_count(
        input logic [COUNT_W-1:0] value
    );
        frame_bytes_t fb;
        fb.hi = {2'b00, value[COUNT_W-1:BYTE_W]};
        fb.lo = value[BYTE_W-1:0];
        return fb;
    endfunction

    function automatic logic [COUNT_W-1:0] join_count(
        input frame_bytes_t fb
    );
        return {fb.hi[COUNT_W-BYTE_W-1:0], fb.lo};
    endfunction

endpackage

// File: rtl/spi_master_byte.sv
// One SPI mode-0 byte shifter: sclk/mosi generation and a done strobe.
// MISO_CAPTURE_EN builds a 16-bit miso shift register sampled on sclk rise.
module spi_master_byte
    import spi_link_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [BYTE_W-1:0]   load_data,
    input  logic                start,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic                done,
    output logic [2*BYTE_W-1:0] rx_shift
);

    localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);

    logic              busy;
    logic [HW-1:0]     half_cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shreg;
    logic              half_end;
    logic              rise;
    logic              fall;

    assign half_end = busy && (half_cnt == HALF_LAST);
    assign rise     = half_end && !sclk;
    assign fall     = half_end && sclk;
    assign done     = fall && (bit_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            half_cnt <= '0;
            bit_idx  <= '0;
            sclk     <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_idx  <= '0;
            sclk     <= 1'b0;
        end else if (busy) begin
            half_cnt <= half_end ? '0 : half_cnt + 1'b1;
            if (rise) begin
                sclk <= 1'b1;
            end
            if (fall) begin
                sclk    <= 1'b0;
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // A load on the last falling edge wins, so the next byte's MSB
    // is presented exactly at that fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            mosi  <= 1'b0;
        end else if (load) begin
            shreg <= load_data;
            mosi  <= load_data[BYTE_W-1];
        end else if (fall && (bit_idx != 3'd7)) begin
            shreg <= {shreg[BYTE_W-2:0], 1'b0};
            mosi  <= shreg[BYTE_W-2];
        end
    end

`ifdef MISO_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
        end else if (rise) begin
            rx_shift <= {rx_shift[2*BYTE_W-2:0], miso};
        end
    end
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_shift    = '0;
`endif

endmodule

// File: rtl/master_counter_tx.sv
// Decimal up-counter that ships every new value as a two-byte SPI frame.
// MISO_CAPTURE_EN enables capture of the slave's reply into o_rx_data.
module master_counter_tx
    import spi_link_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int SCLK_DIV  = 4,
    parameter int COUNT_MAX = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic               i_clear,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               ss,
    output logic [COUNT_W-1:0] o_counter,
    output logic               o_busy,
    output logic [15:0]        o_rx_data
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW    = $clog2(2 * SCLK_DIV);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(COUNT_MAX);
    localparam logic [TW-1:0]      HALF_LAST  = TW'(SCLK_DIV - 1);
    localparam logic [TW-1:0]      SPACE_LAST = TW'(2 * SCLK_DIV - 1);

    logic [DIV_W-1:0]   div_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] snap;
    logic               pending;
    logic               tick;

    link_state_t        state_q;
    link_state_t        state_d;
    logic [TW-1:0]      timer_q;
    logic [TW-1:0]      timer_d;
    logic               ss_q;
    logic               ss_fall;
    logic               ss_rise;
    logic               frame_done;

    logic               byte_load;
    logic               byte_start;
    logic [BYTE_W-1:0]  byte_data;
    logic               byte_done;
    logic               mosi_bit;
    logic [15:0]        rx_shift;

    frame_bytes_t       live;
    frame_bytes_t       frame;

    assign tick  = i_run && (div_q == DIV_LAST);
    assign live  = split_count(count_q);
    assign frame = split_count(snap);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            count_q <= '0;
        end else if (i_clear) begin
            div_q   <= '0;
            count_q <= '0;
        end else if (i_run) begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                count_q <= (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ss_q       <= 1'b1;
            snap       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            frame_done <= ss_rise;
            if (ss_fall) begin
                ss_q <= 1'b0;
                snap <= count_q;
            end else if (ss_rise) begin
                ss_q <= 1'b1;
            end
            // A request arriving on the start edge must survive it.
            if (i_clear || tick) begin
                pending <= 1'b1;
            end else if (ss_fall) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        ss_fall    = 1'b0;
        ss_rise    = 1'b0;
        byte_load  = 1'b0;
        byte_start = 1'b0;
        byte_data  = frame.lo;
        unique case (state_q)
            IDLE: begin
                if (pending) begin
                    ss_fall    = 1'b1;
                    byte_load  = 1'b1;
                    byte_start = 1'b1;
                    byte_data  = live.hi;
                    state_d    = SHIFT0;
                end
            end
            SHIFT0: begin
                if (byte_done) begin
                    byte_load = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (timer_q == HALF_LAST) begin
                    byte_start = 1'b1;
                    state_d    = SHIFT1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SHIFT1: begin
                if (byte_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (timer_q == HALF_LAST) begin
                    ss_rise = 1'b1;
                    state_d = SPACE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SPACE: begin
                if (timer_q == SPACE_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    spi_master_byte #(
        .SCLK_DIV (SCLK_DIV)
    ) u_byte (
        .clk       (clk),
        .reset     (reset),
        .load      (byte_load),
        .load_data (byte_data),
        .start     (byte_start),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi_bit),
        .done      (byte_done),
        .rx_shift  (rx_shift)
    );

    assign ss        = ss_q;
    assign mosi      = ss_q ? 1'b0 : mosi_bit;
    assign o_counter = count_q;
    assign o_busy    = (state_q != IDLE);

`ifdef MISO_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rx_data <= '0;
        end else if (frame_done) begin
            o_rx_data <= rx_shift;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{rx_shift, frame_done};
    assign o_rx_data = '0;
`endif

endmodule
